mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single processor-memory bus between the instruction cache and the data cache controller.
- Grants one requester per cycle and forwards its command, address and data to memory.
- Records which requester owns each accepted load tag, and steers each returned tag/data to that owner only.
- Sits between both caches and the memory model, replacing their direct proc2mem connections.

Parameters:
NUM_MEM_TAGS, 15, number of memory transaction tags; tag 0 means "no tag / rejected"; tag width = $clog2(NUM_MEM_TAGS+1)
DATA_SIZE, 64, memory data bus width in bits
STARVE_LIMIT, 4, consecutive lost cycles after which the icache takes priority for one grant

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
icache_command  input  2  BUS_COMMAND from icache (BUS_NONE/BUS_LOAD; BUS_STORE never issued)
icache_addr  input  32  icache request address
dcache_command  input  2  BUS_COMMAND from dcache controller
dcache_addr  input  32  dcache request address
dcache_data  input  DATA_SIZE  dcache store data
mem_response  input  TW  memory acceptance tag for this cycle's command; 0 = rejected
mem_data  input  DATA_SIZE  memory return data
mem_tag  input  TW  tag of returning data; 0 = none
arb_mem_command  output  2  command to memory
arb_mem_addr  output  32  address to memory
arb_mem_data  output  DATA_SIZE  store data to memory
icache_response  output  TW  acceptance tag to icache
icache_rdata  output  DATA_SIZE  return data to icache
icache_tag  output  TW  return tag to icache
dcache_response  output  TW  acceptance tag to dcache
dcache_rdata  output  DATA_SIZE  return data to dcache
dcache_tag  output  TW  return tag to dcache
icache_grant  output  1  icache owns the bus this cycle
dcache_grant  output  1  dcache owns the bus this cycle
dcache_outstanding  output  TW  number of dcache loads in flight
tag_error  output  1  sticky flag: a tag returned that had no owner

Behaviour:
- Reset (reset=0, asynchronous):
  - Owner table, outstanding count, starve counter and tag_error all clear.
  - Response outputs are combinational and follow their inputs, so they are 0/BUS_NONE while requests and memory inputs are idle.
- Arbitration is combinational, zero latency: a request is any command != BUS_NONE.
  - Only one requests: it is granted.
  - Both request: dcache wins, unless starve_cnt == STARVE_LIMIT, in which case icache wins.
  - Exactly one grant signal is high when any request exists; both are 0 otherwise.
- arb_mem_* carries the granted requester's command, address and data; BUS_NONE, 0, 0 when idle.
  - arb_mem_data equals dcache_data only for a dcache grant, else 0.
- Acceptance responses:
  - The granted requester sees mem_response the same cycle.
  - The non-granted requester sees 0 and must hold and retry.
  - A mem_response of 0 is a rejection; the requester retries and no state changes.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each cycle the icache requests and is not granted.
  - Clears on any icache grant, whether or not memory accepted.
- Owner table: NUM_MEM_TAGS entries of {valid, owner}, indexed by tag.
  - Set on a granted BUS_LOAD with mem_response != 0: entry[mem_response] <= {1, granted_id}.
  - Stores never allocate an entry.
- Return routing (combinational):
  - If mem_tag != 0 and entry[mem_tag] is valid, the owner gets rdata=mem_data and tag=mem_tag; the other requester gets tag 0, rdata 0.
  - The entry clears at the clock edge.
- Unowned return (mem_tag != 0 with an invalid entry):
  - Routed to neither requester.
  - tag_error <= 1 and stays set until reset.
- Same tag returned and re-allocated in the same cycle: the return is routed using the old owner; the new allocation wins in the table (valid stays 1, owner updated).
- dcache_outstanding:
  - Increments on a dcache load allocation and decrements on a dcache-owned return.
  - Both in the same cycle: unchanged.
  - Never exceeds NUM_MEM_TAGS.
- Reset mid-transaction drops all ownership. Tags returning afterwards are unowned and set tag_error.

Test Plan:
- Only dcache BUS_LOAD at addr 0x100, mem_response=3 → dcache_grant=1, dcache_response=3, icache_response=0; dcache_outstanding goes 0→1. Later mem_tag=3, mem_data=0xDEAD → dcache_tag=3, dcache_rdata=0xDEAD, icache_tag=0; dcache_outstanding goes 1→0.
- Both requesting continuously, memory always accepting → dcache granted 4 cycles, icache granted on the 5th, then dcache again; repeating 4:1 pattern.
- dcache BUS_STORE at addr 0x200, data 0x55, mem_response=5 → arb_mem_data=0x55; no owner entry made. A later mem_tag=5 → tag_error=1, both return tags 0.
- icache load tag 2 returns in the same cycle a dcache load is accepted with tag 2 → icache_tag=2; entry 2 now owned by dcache; the next mem_tag=2 routes to dcache.
- mem_response=0 on a granted icache load → icache_response=0, no allocation; starve counter cleared; the retry next cycle is accepted with tag 7.
- Assert reset low with 3 dcache loads outstanding → dcache_outstanding=0 and outputs idle immediately (asynchronously). A subsequent mem_tag=4 → tag_error=1.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared processor-memory bus: icache and dcache controller.
// Grants one requester per cycle and routes returning load tags back to the owner.
module mem_bus_arbiter #(
    parameter int NUM_MEM_TAGS = 15,
    parameter int DATA_SIZE    = 64,
    parameter int STARVE_LIMIT = 4,
    localparam int TW          = $clog2(NUM_MEM_TAGS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           icache_command,
    input  logic [31:0]          icache_addr,
    input  logic [1:0]           dcache_command,
    input  logic [31:0]          dcache_addr,
    input  logic [DATA_SIZE-1:0] dcache_data,
    input  logic [TW-1:0]        mem_response,
    input  logic [DATA_SIZE-1:0] mem_data,
    input  logic [TW-1:0]        mem_tag,
    output logic [1:0]           arb_mem_command,
    output logic [31:0]          arb_mem_addr,
    output logic [DATA_SIZE-1:0] arb_mem_data,
    output logic [TW-1:0]        icache_response,
    output logic [DATA_SIZE-1:0] icache_rdata,
    output logic [TW-1:0]        icache_tag,
    output logic [TW-1:0]        dcache_response,
    output logic [DATA_SIZE-1:0] dcache_rdata,
    output logic [TW-1:0]        dcache_tag,
    output logic                 icache_grant,
    output logic                 dcache_grant,
    output logic [TW-1:0]        dcache_outstanding,
    output logic                 tag_error
);

    localparam int         SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    logic [SW-1:0] r_starve_cnt;
    logic [TW-1:0] r_outstanding;
    logic          r_tag_error;
    logic          r_valid [0:NUM_MEM_TAGS];
    logic          r_owner [0:NUM_MEM_TAGS];   // 1 = dcache, 0 = icache

    logic          w_i_req;
    logic          w_d_req;
    logic          w_i_starved;
    logic          w_i_grant;
    logic          w_d_grant;
    logic [1:0]    w_grant_cmd;
    logic          w_alloc;
    logic          w_ret_in_range;
    logic          w_ret_hit;
    logic          w_ret_owner;
    logic          w_unowned;
    logic          w_d_inc;
    logic          w_d_dec;

    // Arbitration: dcache wins ties unless the icache has lost STARVE_LIMIT cycles in a row.
    assign w_i_req     = (icache_command != BUS_NONE);
    assign w_d_req     = (dcache_command != BUS_NONE);
    assign w_i_starved = (r_starve_cnt == SW'(STARVE_LIMIT));
    assign w_i_grant   = w_i_req && (!w_d_req || w_i_starved);
    assign w_d_grant   = w_d_req && !w_i_grant;

    assign w_grant_cmd = w_i_grant ? icache_command :
                         (w_d_grant ? dcache_command : BUS_NONE);

    assign w_alloc = (w_grant_cmd == BUS_LOAD) && (mem_response != '0) &&
                     (mem_response <= TW'(NUM_MEM_TAGS));

    assign w_ret_in_range = (mem_tag != '0) && (mem_tag <= TW'(NUM_MEM_TAGS));
    assign w_ret_hit      = w_ret_in_range && r_valid[mem_tag];
    assign w_ret_owner    = w_ret_in_range && r_owner[mem_tag];
    assign w_unowned      = (mem_tag != '0) && !w_ret_hit;

    assign w_d_inc = w_alloc && w_d_grant && (r_outstanding != TW'(NUM_MEM_TAGS));
    assign w_d_dec = w_ret_hit && w_ret_owner && (r_outstanding != '0);

    // Allocation takes precedence over the clearing return, so a tag that comes back and
    // is re-issued in the same cycle ends up owned by the new requester.
    generate
        for (genvar gi = 0; gi <= NUM_MEM_TAGS; gi++) begin : g_owner
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_valid[gi] <= 1'b0;
                    r_owner[gi] <= 1'b0;
                end else if (w_alloc && (mem_response == TW'(gi))) begin
                    r_valid[gi] <= 1'b1;
                    r_owner[gi] <= w_d_grant;
                end else if (w_ret_hit && (mem_tag == TW'(gi))) begin
                    r_valid[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_i_grant) begin
            r_starve_cnt <= '0;
        end else if (w_i_req && !w_i_starved) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
        end else if (w_d_inc && !w_d_dec) begin
            r_outstanding <= r_outstanding + TW'(1);
        end else if (w_d_dec && !w_d_inc) begin
            r_outstanding <= r_outstanding - TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag_error <= 1'b0;
        end else if (w_unowned) begin
            r_tag_error <= 1'b1;
        end
    end

    assign icache_grant    = w_i_grant;
    assign dcache_grant    = w_d_grant;
    assign arb_mem_command = w_grant_cmd;
    assign arb_mem_addr    = w_i_grant ? icache_addr : (w_d_grant ? dcache_addr : 32'd0);
    assign arb_mem_data    = w_d_grant ? dcache_data : '0;

    assign icache_response = w_i_grant ? mem_response : '0;
    assign dcache_response = w_d_grant ? mem_response : '0;

    assign icache_tag   = (w_ret_hit && !w_ret_owner) ? mem_tag  : '0;
    assign icache_rdata = (w_ret_hit && !w_ret_owner) ? mem_data : '0;
    assign dcache_tag   = (w_ret_hit &&  w_ret_owner) ? mem_tag  : '0;
    assign dcache_rdata = (w_ret_hit &&  w_ret_owner) ? mem_data : '0;

    assign dcache_outstanding = r_outstanding;
    assign tag_error          = r_tag_error;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, starvation, tag ownership and reset.
module tb_mem_bus_arbiter;

    localparam int NT = 15;
    localparam int DS = 64;
    localparam int TW = 4;
    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    logic          clock;
    logic          reset;
    logic [1:0]    icache_command;
    logic [31:0]   icache_addr;
    logic [1:0]    dcache_command;
    logic [31:0]   dcache_addr;
    logic [DS-1:0] dcache_data;
    logic [TW-1:0] mem_response;
    logic [DS-1:0] mem_data;
    logic [TW-1:0] mem_tag;
    logic [1:0]    arb_mem_command;
    logic [31:0]   arb_mem_addr;
    logic [DS-1:0] arb_mem_data;
    logic [TW-1:0] icache_response;
    logic [DS-1:0] icache_rdata;
    logic [TW-1:0] icache_tag;
    logic [TW-1:0] dcache_response;
    logic [DS-1:0] dcache_rdata;
    logic [TW-1:0] dcache_tag;
    logic          icache_grant;
    logic          dcache_grant;
    logic [TW-1:0] dcache_outstanding;
    logic          tag_error;

    int tests_run;
    int tests_failed;

    mem_bus_arbiter #(.NUM_MEM_TAGS(NT), .DATA_SIZE(DS), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .icache_command(icache_command), .icache_addr(icache_addr),
        .dcache_command(dcache_command), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
        .mem_response(mem_response), .mem_data(mem_data), .mem_tag(mem_tag),
        .arb_mem_command(arb_mem_command), .arb_mem_addr(arb_mem_addr), .arb_mem_data(arb_mem_data),
        .icache_response(icache_response), .icache_rdata(icache_rdata), .icache_tag(icache_tag),
        .dcache_response(dcache_response), .dcache_rdata(dcache_rdata), .dcache_tag(dcache_tag),
        .icache_grant(icache_grant), .dcache_grant(dcache_grant),
        .dcache_outstanding(dcache_outstanding), .tag_error(tag_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        icache_command = NONE; icache_addr = '0;
        dcache_command = NONE; dcache_addr = '0; dcache_data = '0;
        mem_response = '0; mem_data = '0; mem_tag = '0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        idle();
        #2;
        check("rst_cmd", arb_mem_command, NONE);
        check("rst_igrant", icache_grant, 0);
        check("rst_dgrant", dcache_grant, 0);
        check("rst_outst", dcache_outstanding, 0);
        check("rst_tagerr", tag_error, 0);
        tick();
        reset = 1'b1;
        tick();

        // Lone dcache load, accepted with tag 3, then its return.
        dcache_command = LOAD; dcache_addr = 32'h100; mem_response = 4'd3;
        #3;
        check("t1_dgrant", dcache_grant, 1);
        check("t1_igrant", icache_grant, 0);
        check("t1_dresp", dcache_response, 3);
        check("t1_iresp", icache_response, 0);
        check("t1_addr", arb_mem_addr, 32'h100);
        check("t1_cmd", arb_mem_command, LOAD);
        tick();
        check("t1_outst_up", dcache_outstanding, 1);
        idle();
        mem_tag = 4'd3; mem_data = 64'hDEAD;
        #3;
        check("t1_dtag", dcache_tag, 3);
        check("t1_drdata", dcache_rdata, 64'hDEAD);
        check("t1_itag", icache_tag, 0);
        tick();
        check("t1_outst_dn", dcache_outstanding, 0);
        check("t1_tagerr", tag_error, 0);
        idle();

        // Both requesting, memory accepting: 4 dcache grants then 1 icache grant.
        icache_command = LOAD; icache_addr = 32'h40;
        dcache_command = STORE; dcache_addr = 32'h80; dcache_data = 64'h11;
        mem_response = 4'd1;
        for (int k = 0; k < 10; k++) begin
            #3;
            check($sformatf("t2_igrant_c%0d", k), icache_grant, (k % 5 == 4) ? 1 : 0);
            check($sformatf("t2_dgrant_c%0d", k), dcache_grant, (k % 5 == 4) ? 0 : 1);
            check($sformatf("t2_addr_c%0d", k), arb_mem_addr, (k % 5 == 4) ? 32'h40 : 32'h80);
            tick();
        end
        idle();

        // Dcache store with tag 5 allocates nothing; a return of tag 5 is unowned.
        dcache_command = STORE; dcache_addr = 32'h200; dcache_data = 64'h55; mem_response = 4'd5;
        #3;
        check("t3_data", arb_mem_data, 64'h55);
        check("t3_cmd", arb_mem_command, STORE);
        check("t3_dresp", dcache_response, 5);
        tick();
        check("t3_outst", dcache_outstanding, 0);
        idle();
        mem_tag = 4'd5; mem_data = 64'h99;
        #3;
        check("t3_dtag", dcache_tag, 0);
        check("t3_itag", icache_tag, 0);
        tick();
        check("t3_tagerr", tag_error, 1);
        idle();

        // Tag 2 returns to icache while being re-allocated to dcache.
        icache_command = LOAD; icache_addr = 32'h300; mem_response = 4'd2;
        #3;
        check("t4_iresp", icache_response, 2);
        tick();
        idle();
        dcache_command = LOAD; dcache_addr = 32'h400; mem_response = 4'd2;
        mem_tag = 4'd2; mem_data = 64'hAAAA;
        #3;
        check("t4_itag", icache_tag, 2);
        check("t4_irdata", icache_rdata, 64'hAAAA);
        check("t4_dtag_old", dcache_tag, 0);
        check("t4_dresp", dcache_response, 2);
        tick();
        check("t4_outst_up", dcache_outstanding, 1);
        idle();
        mem_tag = 4'd2; mem_data = 64'hBBBB;
        #3;
        check("t4_dtag_new", dcache_tag, 2);
        check("t4_drdata", dcache_rdata, 64'hBBBB);
        check("t4_itag_new", icache_tag, 0);
        tick();
        check("t4_outst_dn", dcache_outstanding, 0);
        idle();

        // Starve the icache, reject its grant, and confirm the counter still cleared.
        icache_command = LOAD; icache_addr = 32'h500;
        dcache_command = STORE; dcache_addr = 32'h600; mem_response = 4'd0;
        for (int k = 0; k < 4; k++) begin
            #3;
            check($sformatf("t5_dgrant_c%0d", k), dcache_grant, 1);
            tick();
        end
        #3;
        check("t5_igrant_starved", icache_grant, 1);
        check("t5_iresp_rej", icache_response, 0);
        tick();
        #3;
        check("t5_dgrant_after", dcache_grant, 1);
        tick();
        dcache_command = NONE; mem_response = 4'd7;
        #3;
        check("t5_iresp_retry", icache_response, 7);
        tick();
        idle();
        mem_tag = 4'd7; mem_data = 64'h7777;
        #3;
        check("t5_itag", icache_tag, 7);
        check("t5_dtag", dcache_tag, 0);
        tick();
        idle();

        // Three dcache loads outstanding, then asynchronous reset mid-cycle.
        dcache_command = LOAD; dcache_addr = 32'h700; mem_response = 4'd4;
        tick();
        mem_response = 4'd6;
        tick();
        mem_response = 4'd8;
        tick();
        check("t6_outst3", dcache_outstanding, 3);
        idle();
        mem_tag = 4'd4;
        reset = 1'b0;
        #1;
        check("t6_rst_outst", dcache_outstanding, 0);
        check("t6_rst_tagerr", tag_error, 0);
        check("t6_rst_cmd", arb_mem_command, NONE);
        check("t6_rst_dtag", dcache_tag, 0);
        #1;
        reset = 1'b1;
        #1;
        check("t6_dtag_unowned", dcache_tag, 0);
        tick();
        check("t6_tagerr", tag_error, 1);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
